// File: rtl/alu_mc_if.sv
// Operation request/response bundle between the datapath controller and alu_mc.
interface alu_mc_if #(
    parameter int W = 8
);
    logic         start;
    logic [2:0]   control;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         busy;
    logic         done;
    logic         co;
    logic         ovf;
    logic         z;
    logic         n;

    modport master (
        output start, control, A, B,
        input  out, out_hi, busy, done, co, ovf, z, n
    );

    modport slave (
        input  start, control, A, B,
        output out, out_hi, busy, done, co, ovf, z, n
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/XOR, sequential signed
// shift-add multiplier, registered NZCV flags and start/done handshake.
module alu_mc #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic      clk,
    input  logic      reset,
    alu_mc_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t          state;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic            sign;
    logic [CW-1:0]   cnt;

    logic [W:0]      sum_add;
    logic [W:0]      sum_sub;
    logic [W-1:0]    r_out;
    logic            r_co;
    logic            r_ovf;
    logic            r_z;
    logic            r_n;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [2*W-1:0]  acc_step;
    logic [2*W-1:0]  prod;

    // Single-cycle result/flags from the live operands, plus the multiplier step.
    always_comb begin
        sum_add = {1'b0, bus.A} + {1'b0, bus.B};
        sum_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + (W+1)'(1);
        r_out   = '0;
        r_co    = 1'b0;
        r_ovf   = 1'b0;
        case (op_t'(bus.control))
            OP_ADD: begin
                r_out = sum_add[W-1:0];
                r_co  = sum_add[W];
                r_ovf = (bus.A[W-1] == bus.B[W-1]) && (sum_add[W-1] != bus.A[W-1]);
            end
            OP_SUB: begin
                r_out = sum_sub[W-1:0];
                r_co  = sum_sub[W];
                r_ovf = (bus.A[W-1] != bus.B[W-1]) && (sum_sub[W-1] != bus.A[W-1]);
            end
            OP_AND:  r_out = bus.A & bus.B;
            OP_OR:   r_out = bus.A | bus.B;
            OP_XOR:  r_out = bus.A ^ bus.B;
            default: r_out = '0;
        endcase
        r_z = (r_out == '0);
        // Sign of the infinite-precision result, not just the truncated MSB.
        r_n = r_out[W-1] ^ r_ovf;

        // Magnitude of -2^(W-1) wraps to 2^(W-1), which is correct as unsigned.
        mag_a    = bus.A[W-1] ? (~bus.A + W'(1)) : bus.A;
        mag_b    = bus.B[W-1] ? (~bus.B + W'(1)) : bus.B;
        acc_step = acc + (mplier[0] ? mcand : '0);
        prod     = sign ? (~acc_step + (2*W)'(1)) : acc_step;
    end

    // Control FSM, multiplier datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            sign       <= 1'b0;
            cnt        <= '0;
            bus.out    <= '0;
            bus.out_hi <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.co     <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.z      <= 1'b0;
            bus.n      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (op_t'(bus.control) == OP_MUL) begin
                            mcand    <= {{W{1'b0}}, mag_a};
                            mplier   <= mag_b;
                            sign     <= bus.A[W-1] ^ bus.B[W-1];
                            acc      <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= S_MUL;
                        end else begin
                            bus.out    <= r_out;
                            bus.out_hi <= '0;
                            bus.co     <= r_co;
                            bus.ovf    <= r_ovf;
                            bus.z      <= r_z;
                            bus.n      <= r_n;
                            bus.done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // The last step's sum is written straight out, already sign-applied.
                    if (cnt == CW'(W - 1)) begin
                        bus.out    <= prod[W-1:0];
                        bus.out_hi <= prod[2*W-1:W];
                        bus.co     <= 1'b0;
                        bus.ovf    <= (prod[2*W-1:W] != {W{prod[W-1]}});
                        bus.z      <= (prod == '0);
                        bus.n      <= prod[2*W-1];
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Randomised scoreboard bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 8;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic [W-1:0] out_hi;
        logic         co;
        logic         ovf;
        logic         z;
        logic         n;
        int           cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];

    alu_mc_if #(.W(W)) bus ();

    alu_mc #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, used to check completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb_, ua, ub, r;
        longint smax, smin;
        logic [2*W-1:0] p;
        sa   = longint'($signed(a));
        sb_  = longint'($signed(b));
        ua   = longint'(a);
        ub   = longint'(b);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        e.op = op; e.a = a; e.b = b;
        e.out = '0; e.out_hi = '0; e.co = 0; e.ovf = 0; e.z = 0; e.n = 0; e.cyc = 0;
        case (op)
            3'd0, 3'd1: begin
                r = (op == 3'd0) ? sa + sb_ : sa - sb_;
                e.out = r[W-1:0];
                e.co  = (op == 3'd0) ? ((ua + ub) >= (longint'(1) << W)) : (ua >= ub);
                e.ovf = (r > smax) || (r < smin);
                e.n   = (r < 0);
                e.z   = (e.out == '0);
            end
            3'd2, 3'd3, 3'd4: begin
                e.out = (op == 3'd2) ? (a & b) : (op == 3'd3) ? (a | b) : (a ^ b);
                e.n   = e.out[W-1];
                e.z   = (e.out == '0);
            end
            3'd5: begin
                r = sa * sb_;
                p = r[2*W-1:0];
                e.out    = p[W-1:0];
                e.out_hi = p[2*W-1:W];
                e.ovf    = (r > smax) || (r < smin);
                e.n      = (r < 0);
                e.z      = (r == 0);
            end
            default: e.z = 1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops and checks one expected response.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out !== e.out || bus.out_hi !== e.out_hi || bus.co !== e.co ||
                    bus.ovf !== e.ovf || bus.z !== e.z || bus.n !== e.n ||
                    bus.busy !== 1'b0 || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL op%0d a=%0h b=%0h: got out=%0h hi=%0h c=%0b v=%0b z=%0b n=%0b busy=%0b cyc=%0d required out=%0h hi=%0h c=%0b v=%0b z=%0b n=%0b busy=0 cyc=%0d",
                             e.op, e.a, e.b, bus.out, bus.out_hi, bus.co, bus.ovf, bus.z, bus.n,
                             bus.busy, cyc, e.out, e.out_hi, e.co, e.ovf, e.z, e.n, e.cyc);
                end
            end
        end
    end

    // Issue one operation (caller sits just after a rising edge); optionally
    // pokes ignored starts with junk operands while a MUL is in flight.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit stray);
        exp_t e;
        e = model(op, a, b);
        bus.start = 1'b1; bus.control = op; bus.A = a; bus.B = b;
        e.cyc = cyc + 1 + ((op == 3'd5) ? W : 0);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (op == 3'd5) begin
            for (int unsigned i = 0; i < W; i++) begin
                bus.control = 3'($urandom_range(0, 7));
                bus.A = W'($urandom); bus.B = W'($urandom);
                bus.start = stray && ($urandom_range(0, 2) == 0);
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic idle(input int unsigned nc);
        for (int unsigned i = 0; i < nc; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {1'b1, {(W-1){1'b0}}};
            2: return {1'b0, {(W-1){1'b1}}};
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; tests = 0; fails = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.control = '0; bus.A = '0; bus.B = '0;
        idle(3);
        chk("reset_out",    bus.out, 0);
        chk("reset_out_hi", bus.out_hi, 0);
        chk("reset_flags",  {bus.busy, bus.done, bus.co, bus.ovf, bus.z, bus.n}, 0);
        reset = 1'b0;
        idle(1);

        // Directed sequence from the plan, with back-to-back single-cycle ops.
        issue(3'd0, 8'h7F, 8'h01, 0);
        issue(3'd1, 8'h05, 8'h05, 0);
        issue(3'd1, 8'h03, 8'h05, 0);
        issue(3'd4, 8'hF0, 8'hFF, 0);
        idle(2);
        issue(3'd5, 8'hFD, 8'h05, 1);
        issue(3'd5, 8'h80, 8'h80, 1);
        issue(3'd5, 8'h80, 8'h00, 0);
        issue(3'd5, 8'h00, 8'hF3, 0);
        issue(3'd6, 8'h12, 8'h34, 0);
        issue(3'd7, 8'hFF, 8'hFF, 0);
        issue(3'd0, 8'h80, 8'h80, 0);

        // Reset in the middle of a MUL: no completion, outputs cleared.
        bus.start = 1'b1; bus.control = 3'd5; bus.A = 8'h7F; bus.B = 8'h7F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idle(3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out",    bus.out, 0);
        chk("abort_out_hi", bus.out_hi, 0);
        chk("abort_flags",  {bus.busy, bus.done, bus.co, bus.ovf, bus.z, bus.n}, 0);
        idle(W + 2);
        chk("abort_no_done_pending", sb.size(), 0);
        issue(3'd5, 8'hFD, 8'h05, 0);

        for (int k = 0; k < 200; k++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        for (int k = 0; k < 40 && sb.size() != 0; k++) idle(1);
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
